// File: rtl/adsr_if.sv
// Control and envelope bundle between the gate/rate source and the ADSR envelope generator.
interface adsr_if;
  logic        gate;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [15:0] env;
  logic [2:0]  stage;
  logic        busy;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  env, stage, busy
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate,
    output env, stage, busy
  );
endinterface

// File: rtl/adsr_env.sv
// ADSR envelope generator: turns a note gate into a 16-bit amplitude envelope,
// stepping once per prescaled tick with runtime rates and sustain level.
module adsr_env #(
  parameter int unsigned CLKSPEED = 50_000_000,
  parameter int unsigned TICK_HZ  = 50_000
) (
  input  logic   clk,
  input  logic   rst_n,
  adsr_if.slave  bus
);

  localparam int unsigned TICK_DIV = CLKSPEED / TICK_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ENV_W    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q;
  stage_e           state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic             busy_q, busy_d;

  logic             tick_c, rise_c, fall_c;
  logic [ENV_W:0]   att_sum_c, dec_diff_c, rel_diff_c;

  // Prescaler and gate edge detection
  assign tick_c = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  assign rise_c = bus.gate & ~gate_q;
  assign fall_c = ~bus.gate & gate_q;

  // One extra bit so overshoot/underflow is visible instead of wrapping
  assign att_sum_c  = {1'b0, env_q} + {1'b0, bus.attack_rate};
  assign dec_diff_c = {1'b0, env_q} - {1'b0, bus.decay_rate};
  assign rel_diff_c = {1'b0, env_q} - {1'b0, bus.release_rate};

  // Next-state: an accepted gate edge wins over the tick and holds env
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise_c) begin
      state_d = ATTACK;
    end else if (fall_c && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick_c) begin
      unique case (state_q)
        IDLE: env_d = '0;
        ATTACK: begin
          if (bus.attack_rate == '0 || att_sum_c >= (ENV_W+1)'(17'h0FFFF)) begin
            env_d   = '1;
            state_d = DECAY;
          end else begin
            env_d = att_sum_c[ENV_W-1:0];
          end
        end
        DECAY: begin
          if (bus.decay_rate == '0 ||
              $signed(dec_diff_c) <= $signed({1'b0, bus.sustain_level})) begin
            env_d   = bus.sustain_level;
            state_d = SUSTAIN;
          end else begin
            env_d = dec_diff_c[ENV_W-1:0];
          end
        end
        SUSTAIN: env_d = bus.sustain_level;
        RELEASE: begin
          if (bus.release_rate == '0 || $signed(rel_diff_c) <= $signed((ENV_W+1)'(0))) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = rel_diff_c[ENV_W-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      state_q <= IDLE;
      env_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gate_q  <= bus.gate;
      state_q <= state_d;
      env_q   <= env_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.env   = env_q;
  assign bus.stage = state_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
- ADSR envelope generator that sits directly upstream of the synth voice.
- Converts the note gate into a 16-bit amplitude envelope that drives the voice's amp_in port, alongside the same gate.
- Envelope advances once per prescaled tick; per-stage step sizes and sustain level are runtime inputs.

Parameters:
- CLKSPEED, 50_000_000: system clock frequency in Hz.
- TICK_HZ, 50_000: envelope update rate in Hz. TICK_DIV = CLKSPEED/TICK_HZ; TICK_DIV must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- gate  input  1  note-on level (high = key held); synchronous to clk.
- attack_rate  input  16  per-tick increment in ATTACK; 0 = instant.
- decay_rate  input  16  per-tick decrement in DECAY; 0 = instant.
- sustain_level  input  16  SUSTAIN target level.
- release_rate  input  16  per-tick decrement in RELEASE; 0 = instant.
- env  output  16  envelope value, registered; connects to voice amp_in.
- stage  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  output  1  high whenever stage != IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - env=0, stage=IDLE, busy=0.
  - Prescaler=0, gate_q=0.
  - Reset overrides all other events in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high in the cycle where count==TICK_DIV-1.
  - env changes only on tick cycles, except on the reset path.
- Gate sampling:
  - gate_q <= gate every cycle.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
  - A gate already high when reset releases gives a rise on the first post-reset cycle.
- Event priority per cycle: reset > rise > fall > tick step.
  - If an edge coincides with a tick, the stage changes and env holds for that tick.
- Rise: from any state, stage <= ATTACK. env is kept, not zeroed (retrigger from the current level, no click).
- Fall: from ATTACK, DECAY or SUSTAIN, stage <= RELEASE; ignored in IDLE and RELEASE.
- Tick step (17-bit arithmetic, no wrap):
  - IDLE: env holds at 0.
  - ATTACK: s = env + attack_rate.
    - If s >= 0xFFFF or attack_rate==0: env=0xFFFF, stage=DECAY.
    - Else env=s.
  - DECAY: s = env - decay_rate.
    - If decay_rate==0, or s <= sustain_level (signed compare): env=sustain_level, stage=SUSTAIN.
    - Else env=s.
    - sustain_level=0xFFFF gives SUSTAIN on the first DECAY tick.
  - SUSTAIN: env = sustain_level each tick, so it tracks live changes.
  - RELEASE: s = env - release_rate.
    - If release_rate==0 or s <= 0: env=0, stage=IDLE.
    - Else env=s.
- Latency:
  - stage responds one clk after gate changes.
  - env starts moving on the first tick after that.
- Rate inputs are sampled at each tick. Changing them mid-stage affects only subsequent ticks.
- Reset mid-envelope: env is forced to 0 immediately; no release ramp.

Test Plan:
All scenarios use CLKSPEED=4, TICK_HZ=1 (TICK_DIV=4), attack_rate=0x4000, decay_rate=0x1000, sustain_level=0xC000, release_rate=0x8000.
1. Full cycle: hold gate high.
   - env on successive ticks = 0x4000, 0x8000, 0xC000, 0xFFFF (stage→DECAY).
   - Then 0xEFFF, 0xDFFF, 0xCFFF, 0xC000 (stage→SUSTAIN).
2. From SUSTAIN, drop gate → stage=RELEASE next clk; env 0x4000, then 0x0000 with stage=IDLE and busy=0 on the same tick.
3. Retrigger: raise gate during RELEASE at env=0x4000 → stage=ATTACK, env continues 0x8000, 0xC000, 0xFFFF; never drops to 0.
4. Instant rates: attack_rate=0, gate high → env=0xFFFF on first tick, stage=DECAY. Then release_rate=0 with gate low → env=0 and IDLE on the next tick.
5. Edge and tick collide: gate rises in a tick cycle → stage=ATTACK, env unchanged that cycle; first increment on the following tick.
6. Reset mid-DECAY: rst_n low for 1 clk → env=0, stage=IDLE, busy=0. With gate still high, stage=ATTACK on the first cycle after release.
